// File: rtl/udma_tx_mchan_arb_pkg.sv
// Shared types for the multi-channel uDMA Tx read arbiter: transfer size codes,
// the outstanding-read tag and the response alignment helper.
package udma_tx_mchan_arb_pkg;

    localparam int CH_ID_W = 4;
    localparam int TAG_W   = CH_ID_W + 4;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic [CH_ID_W-1:0] ch_id;
        logic [1:0]         offs;
        logic [1:0]         size;
    } tag_t;

    // Reserved size code 3 falls into the word case.
    function automatic logic [31:0] align_rdata(logic [31:0] d, logic [1:0] offs, logic [1:0] size);
        logic [31:0] r;
        case (size)
            SIZE_BYTE: r = {24'h0, d[8*offs +: 8]};
            SIZE_HALF: r = {16'h0, (offs[1] ? d[31:16] : d[15:0])};
            default:   r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/udma_tx_mchan_arb_if.sv
// Channel-side and L2-side signals of the Tx read arbiter; master is the arbiter,
// slave is the environment driving channels and the L2 port.
interface udma_tx_mchan_arb_if #(
    parameter int N_CH   = 4,
    parameter int ADDR_W = 19
);
    logic [N_CH-1:0]        ch_en_i;
    logic [N_CH-1:0]        ch_req_i;
    logic [N_CH*ADDR_W-1:0] ch_addr_i;
    logic [N_CH*2-1:0]      ch_size_i;
    logic [N_CH-1:0]        ch_gnt_o;
    logic [N_CH-1:0]        ch_rvalid_o;
    logic [31:0]            ch_rdata_o;
    logic                   l2_req_o;
    logic [ADDR_W-1:0]      l2_addr_o;
    logic                   l2_gnt_i;
    logic                   l2_rvalid_i;
    logic [31:0]            l2_rdata_i;
    logic                   err_o;

    modport master (
        input  ch_en_i, ch_req_i, ch_addr_i, ch_size_i, l2_gnt_i, l2_rvalid_i, l2_rdata_i,
        output ch_gnt_o, ch_rvalid_o, ch_rdata_o, l2_req_o, l2_addr_o, err_o
    );

    modport slave (
        output ch_en_i, ch_req_i, ch_addr_i, ch_size_i, l2_gnt_i, l2_rvalid_i, l2_rdata_i,
        input  ch_gnt_o, ch_rvalid_o, ch_rdata_o, l2_req_o, l2_addr_o, err_o
    );

endinterface

// File: rtl/udma_tx_tag_fifo.sv
// In-order tag FIFO for outstanding L2 reads; head visible combinationally, push
// ignored when full, pop ignored when empty.
module udma_tx_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       i_push,
    input  logic [W-1:0]               i_dat,
    input  logic                       i_pop,
    output logic [W-1:0]               o_dat,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dat   = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= i_dat;
    end

endmodule

// File: rtl/udma_tx_mchan_arb.sv
// N-channel round-robin L2 read arbiter with in-order response routing; request path
// is zero-latency, responses land 1 cycle after l2_rvalid_i; a full tag FIFO holds off l2_req_o.
module udma_tx_mchan_arb
    import udma_tx_mchan_arb_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 19
) (
    input  logic                clk_i,
    input  logic                rst_i,
    udma_tx_mchan_arb_if.master bus
);
    localparam int CH_W  = $clog2(N_CH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [N_CH-1:0] ONE = N_CH'(1);

    logic [CH_W-1:0]   r_rr_ptr;
    logic              r_lock;
    logic [CH_W-1:0]   r_lock_ch;
    logic [ADDR_W-1:0] r_lock_addr;
    logic [1:0]        r_lock_size;
    logic [N_CH-1:0]   r_rvalid;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic [N_CH-1:0]   w_elig;
    logic              w_found;
    logic [CH_W-1:0]   w_rr_sel;
    logic [CH_W-1:0]   w_sel;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        w_size;
    logic              w_req;
    logic              w_accept;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    tag_t              w_push_tag;
    tag_t              w_head;

    assign w_elig = bus.ch_req_i & bus.ch_en_i;

    always_comb begin
        w_found  = 1'b0;
        w_rr_sel = r_rr_ptr;
        for (int i = 0; i < N_CH; i++) begin
            int idx;
            idx = int'(r_rr_ptr) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!w_found && w_elig[idx]) begin
                w_found  = 1'b1;
                w_rr_sel = CH_W'(idx);
            end
        end
    end

    // A pending request keeps its channel, address and size until L2 accepts it.
    assign w_sel    = r_lock ? r_lock_ch   : w_rr_sel;
    assign w_addr   = r_lock ? r_lock_addr : bus.ch_addr_i[w_rr_sel*ADDR_W +: ADDR_W];
    assign w_size   = r_lock ? r_lock_size : bus.ch_size_i[w_rr_sel*2 +: 2];
    assign w_req    = (w_found | r_lock) & ~w_full;
    assign w_accept = w_req & bus.l2_gnt_i;

    assign w_push_tag = '{ch_id: CH_ID_W'(w_sel), offs: w_addr[1:0], size: w_size};

    assign bus.l2_req_o    = w_req;
    assign bus.l2_addr_o   = w_req ? {w_addr[ADDR_W-1:2], 2'b00} : '0;
    assign bus.ch_gnt_o    = w_accept ? (ONE << w_sel) : '0;
    assign bus.ch_rvalid_o = r_rvalid;
    assign bus.ch_rdata_o  = r_rdata;
    assign bus.err_o       = r_err;

    udma_tx_tag_fifo #(
        .DEPTH (DEPTH),
        .W     (TAG_W)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_accept),
        .i_dat   (w_push_tag),
        .i_pop   (bus.l2_rvalid_i),
        .o_dat   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr    <= '0;
            r_lock      <= 1'b0;
            r_lock_ch   <= '0;
            r_lock_addr <= '0;
            r_lock_size <= '0;
            r_rvalid    <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_lock   <= 1'b0;
                r_rr_ptr <= (w_sel == CH_W'(N_CH - 1)) ? '0 : w_sel + CH_W'(1);
            end else if (w_req && !r_lock) begin
                r_lock      <= 1'b1;
                r_lock_ch   <= w_sel;
                r_lock_addr <= w_addr;
                r_lock_size <= w_size;
            end

            r_rvalid <= '0;
            if (bus.l2_rvalid_i) begin
                if (!w_empty) begin
                    r_rvalid <= ONE << w_head.ch_id;
                    r_rdata  <= align_rdata(bus.l2_rdata_i, w_head.offs, w_head.size);
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) assert (w_count <= CNT_W'(DEPTH));
    end

endmodule
